sram_scheduler: RTL and testbench

- Time-slot scheduler for the single external 8-bit SRAM in the CPC core, clocked at 16 MHz.
- Serves three requesters: video fetch (fixed slots), CPU memory path, and the host ROM/boot loader.
- Drives the SRAM address, data and write-enable pins.
- Sits between the memory manager (CPU side) / boot loader and the SRAM pad logic.

---
 rtl/sram_scheduler_pkg.sv | 37 +++
 rtl/sram_slot_timer.sv | 38 +++
 rtl/sram_scheduler.sv | 204 ++++++++++++++++++++
 tb/tb_sram_scheduler.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_scheduler_pkg.sv
// Shared window/phase encodings and the owner type for the SRAM time-slot scheduler.
// The grant rule per window lives here so the top and any checker agree on it.
package sram_scheduler_pkg;

  localparam logic [1:0] WIN_VID0 = 2'd0;
  localparam logic [1:0] WIN_VID1 = 2'd1;
  localparam logic [1:0] WIN_CPU  = 2'd2;
  localparam logic [1:0] WIN_HOST = 2'd3;

  localparam logic [1:0] P_ADDR  = 2'd0;
  localparam logic [1:0] P_WE1   = 2'd1;
  localparam logic [1:0] P_WE2   = 2'd2;
  localparam logic [1:0] P_LATCH = 2'd3;

  typedef enum logic [1:0] {
    OWN_VID  = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_HOST = 2'd2,
    OWN_IDLE = 2'd3
  } own_e;

  // cpu_ok/host_ok are the requests already masked by any ack issued on this edge.
  function automatic own_e grant_owner(input logic [1:0] win,
                                       input logic       cpu_ok,
                                       input logic       host_ok);
    own_e own;
    own = OWN_IDLE;
    case (win)
      WIN_VID0, WIN_VID1: own = OWN_VID;
      WIN_CPU:  own = cpu_ok  ? OWN_CPU  : (host_ok ? OWN_HOST : OWN_IDLE);
      WIN_HOST: own = host_ok ? OWN_HOST : (cpu_ok  ? OWN_CPU  : OWN_IDLE);
      default:  own = OWN_IDLE;
    endcase
    return own;
  endfunction

endpackage

// File: rtl/sram_slot_timer.sv
// 16-slot counter split into window (top 2 bits) and phase (bottom 2 bits).
// resync forces the next slot to 0; an edge ending P3 always completes normally.
module sram_slot_timer
  import sram_scheduler_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       resync,
  output logic [1:0] win,
  output logic [1:0] next_win,
  output logic [1:0] next_phase,
  output logic       end_p3,
  output logic       abort
);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  always_comb begin
    cnt_d = resync ? 4'd0 : cnt_q + 4'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign win        = cnt_q[3:2];
  assign next_win   = cnt_d[3:2];
  assign next_phase = cnt_d[1:0];
  assign end_p3     = (cnt_q[1:0] == P_LATCH);
  // resync in P3 is just an early wrap; anywhere else it kills the window in flight
  assign abort      = resync && (cnt_q[1:0] != P_LATCH);

endmodule

// File: rtl/sram_scheduler.sv
// Time-slot scheduler for the single 8-bit SRAM: video in W0/W1, CPU and host in W2/W3.
// All pad-facing outputs are registered so rst can drop sram_we_n asynchronously.
module sram_scheduler
  import sram_scheduler_pkg::*;
#(
  parameter int                 ADDR_W    = 21,
  parameter logic [ADDR_W-17:0] VRAM_BASE = '0
) (
  input  logic              ck16,
  input  logic              rst,
  input  logic              resync,
  input  logic [15:0]       vid_addr,
  output logic [15:0]       vid_data,
  output logic              vid_strobe,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic [7:0]        cpu_rdata,
  output logic              cpu_ack,
  input  logic              host_req,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [7:0]        host_wdata,
  output logic              host_ack,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [7:0]        sram_dout,
  output logic              sram_dout_oe,
  input  logic [7:0]        sram_din,
  output logic              sram_we_n
);

  logic [1:0] win;
  logic [1:0] next_win;
  logic [1:0] next_phase;
  logic       end_p3;
  logic       abort;

  sram_slot_timer u_timer (
    .clk        (ck16),
    .rst        (rst),
    .resync     (resync),
    .win        (win),
    .next_win   (next_win),
    .next_phase (next_phase),
    .end_p3     (end_p3),
    .abort      (abort)
  );

  logic vid_addr_unused;
  assign vid_addr_unused = vid_addr[0];

  own_e              owner_q, owner_d;
  logic              wr_q, wr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic [7:0]        vid_even_q, vid_even_d;
  logic              vid_even_valid_q, vid_even_valid_d;
  logic [15:0]       vid_data_q, vid_data_d;
  logic              vid_strobe_q, vid_strobe_d;
  logic [7:0]        cpu_rdata_q, cpu_rdata_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic              host_ack_q, host_ack_d;
  logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
  logic [7:0]        sram_dout_q, sram_dout_d;
  logic              sram_dout_oe_q, sram_dout_oe_d;
  logic              sram_we_n_q, sram_we_n_d;

  logic cpu_acking;
  logic host_acking;

  // A requester whose ack goes out on this edge still has req high; keep it out of the next window.
  assign cpu_acking  = end_p3 && (owner_q == OWN_CPU);
  assign host_acking = end_p3 && (owner_q == OWN_HOST);

  always_comb begin
    owner_d          = owner_q;
    wr_d             = wr_q;
    wdata_d          = wdata_q;
    vid_even_d       = vid_even_q;
    vid_even_valid_d = vid_even_valid_q;
    vid_data_d       = vid_data_q;
    vid_strobe_d     = 1'b0;
    cpu_rdata_d      = cpu_rdata_q;
    cpu_ack_d        = 1'b0;
    host_ack_d       = 1'b0;
    sram_addr_d      = sram_addr_q;
    sram_dout_d      = sram_dout_q;
    sram_dout_oe_d   = sram_dout_oe_q;
    sram_we_n_d      = sram_we_n_q;

    case (next_phase)
      P_ADDR: begin
        owner_d        = grant_owner(next_win, cpu_req && !cpu_acking,
                                     host_req && !host_acking);
        sram_we_n_d    = 1'b1;
        sram_dout_oe_d = 1'b0;
        wr_d           = 1'b0;
        case (owner_d)
          OWN_VID: begin
            sram_addr_d = {VRAM_BASE, vid_addr[15:1], next_win[0]};
          end
          OWN_CPU: begin
            sram_addr_d = cpu_addr;
            wr_d        = cpu_we;
            wdata_d     = cpu_wdata;
          end
          OWN_HOST: begin
            sram_addr_d = host_addr;
            wr_d        = 1'b1;
            wdata_d     = host_wdata;
          end
          default: begin
            sram_addr_d = sram_addr_q;
          end
        endcase
      end
      P_WE1, P_WE2: begin
        if (wr_q) begin
          sram_we_n_d    = 1'b0;
          sram_dout_oe_d = 1'b1;
          sram_dout_d    = wdata_q;
        end
      end
      default: begin
        // P3: close the write strobe, keep data driven for hold time
        sram_we_n_d = 1'b1;
      end
    endcase

    if (abort) begin
      vid_even_valid_d = 1'b0;
    end

    if (end_p3) begin
      case (owner_q)
        OWN_VID: begin
          if (win == WIN_VID0) begin
            vid_even_d       = sram_din;
            vid_even_valid_d = 1'b1;
          end else if (vid_even_valid_q) begin
            vid_data_d       = {sram_din, vid_even_q};
            vid_strobe_d     = 1'b1;
            vid_even_valid_d = 1'b0;
          end
        end
        OWN_CPU: begin
          cpu_ack_d = 1'b1;
          if (!wr_q) begin
            cpu_rdata_d = sram_din;
          end
        end
        OWN_HOST: begin
          host_ack_d = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge ck16 or posedge rst) begin
    if (rst) begin
      owner_q          <= OWN_IDLE;
      wr_q             <= 1'b0;
      wdata_q          <= 8'd0;
      vid_even_q       <= 8'd0;
      vid_even_valid_q <= 1'b0;
      vid_data_q       <= 16'd0;
      vid_strobe_q     <= 1'b0;
      cpu_rdata_q      <= 8'd0;
      cpu_ack_q        <= 1'b0;
      host_ack_q       <= 1'b0;
      sram_addr_q      <= '0;
      sram_dout_q      <= 8'd0;
      sram_dout_oe_q   <= 1'b0;
      sram_we_n_q      <= 1'b1;
    end else begin
      owner_q          <= owner_d;
      wr_q             <= wr_d;
      wdata_q          <= wdata_d;
      vid_even_q       <= vid_even_d;
      vid_even_valid_q <= vid_even_valid_d;
      vid_data_q       <= vid_data_d;
      vid_strobe_q     <= vid_strobe_d;
      cpu_rdata_q      <= cpu_rdata_d;
      cpu_ack_q        <= cpu_ack_d;
      host_ack_q       <= host_ack_d;
      sram_addr_q      <= sram_addr_d;
      sram_dout_q      <= sram_dout_d;
      sram_dout_oe_q   <= sram_dout_oe_d;
      sram_we_n_q      <= sram_we_n_d;
    end
  end

  assign vid_data     = vid_data_q;
  assign vid_strobe   = vid_strobe_q;
  assign cpu_rdata    = cpu_rdata_q;
  assign cpu_ack      = cpu_ack_q;
  assign host_ack     = host_ack_q;
  assign sram_addr    = sram_addr_q;
  assign sram_dout    = sram_dout_q;
  assign sram_dout_oe = sram_dout_oe_q;
  assign sram_we_n    = sram_we_n_q;

endmodule

// File: tb/tb_sram_scheduler.sv
// Directed bench for sram_scheduler: video fetch, CPU read, contention, resync abort, async reset.
// cnt_m is the bench's own model of the slot counter; inputs change and outputs are sampled on negedge.
module tb_sram_scheduler;

  localparam int ADDR_W = 21;

  logic              ck16 = 1'b0;
  logic              rst;
  logic              resync;
  logic [15:0]       vid_addr;
  logic [15:0]       vid_data;
  logic              vid_strobe;
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [7:0]        cpu_wdata;
  logic [7:0]        cpu_rdata;
  logic              cpu_ack;
  logic              host_req;
  logic [ADDR_W-1:0] host_addr;
  logic [7:0]        host_wdata;
  logic              host_ack;
  logic [ADDR_W-1:0] sram_addr;
  logic [7:0]        sram_dout;
  logic              sram_dout_oe;
  logic [7:0]        sram_din;
  logic              sram_we_n;

  sram_scheduler #(.ADDR_W(ADDR_W), .VRAM_BASE(5'b00000)) dut (
    .ck16         (ck16),
    .rst          (rst),
    .resync       (resync),
    .vid_addr     (vid_addr),
    .vid_data     (vid_data),
    .vid_strobe   (vid_strobe),
    .cpu_req      (cpu_req),
    .cpu_we       (cpu_we),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_rdata    (cpu_rdata),
    .cpu_ack      (cpu_ack),
    .host_req     (host_req),
    .host_addr    (host_addr),
    .host_wdata   (host_wdata),
    .host_ack     (host_ack),
    .sram_addr    (sram_addr),
    .sram_dout    (sram_dout),
    .sram_dout_oe (sram_dout_oe),
    .sram_din     (sram_din),
    .sram_we_n    (sram_we_n)
  );

  // clock/reset block
  always #5 ck16 = ~ck16;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_fail   = 0;
  int cnt_m    = 0;
  int cpu_ack_cnt  = 0;
  int host_ack_cnt = 0;
  int we_low_cnt   = 0;

  always @(negedge ck16) begin
    if (cpu_ack)    cpu_ack_cnt++;
    if (host_ack)   host_ack_cnt++;
    if (!sram_we_n) we_low_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (slot %0d)", tag, got, exp, cnt_m);
    end
  endtask

  // driver tasks
  task automatic next_cycle();
    @(posedge ck16);
    if (rst || resync) cnt_m = 0;
    else cnt_m = (cnt_m + 1) % 16;
    @(negedge ck16);
  endtask

  task automatic run_to(input int target);
    int guard;
    guard = 0;
    while (cnt_m != target && guard < 40) begin
      next_cycle();
      guard++;
    end
    if (cnt_m != target) check_eq("run_to_budget", cnt_m, target);
  endtask

  task automatic clear_monitors();
    cpu_ack_cnt  = 0;
    host_ack_cnt = 0;
    we_low_cnt   = 0;
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_we_n"},     sram_we_n,    1);
    check_eq({tag, "_oe"},       sram_dout_oe, 0);
    check_eq({tag, "_addr"},     sram_addr,    0);
    check_eq({tag, "_dout"},     sram_dout,    0);
    check_eq({tag, "_vid_data"}, vid_data,     0);
    check_eq({tag, "_strobe"},   vid_strobe,   0);
    check_eq({tag, "_rdata"},    cpu_rdata,    0);
    check_eq({tag, "_cpu_ack"},  cpu_ack,      0);
    check_eq({tag, "_host_ack"}, host_ack,     0);
  endtask

  initial begin
    rst        = 1'b1;
    resync     = 1'b0;
    vid_addr   = 16'h1235;
    cpu_req    = 1'b0;
    cpu_we     = 1'b0;
    cpu_addr   = '0;
    cpu_wdata  = 8'h00;
    host_req   = 1'b0;
    host_addr  = '0;
    host_wdata = 8'h00;
    sram_din   = 8'h00;
    repeat (3) @(negedge ck16);
    cnt_m = 0;
    check_reset_values("reset");
    rst = 1'b0;

    // Video only: first frame after reset has no W0 fetch, so no strobe
    run_to(8);
    check_eq("vid_no_strobe_first_frame", vid_strobe, 0);
    run_to(0);
    clear_monitors();
    check_eq("vid_addr_even", sram_addr, 21'h01234);
    sram_din = 8'hAA;
    run_to(4);
    check_eq("vid_addr_odd", sram_addr, 21'h01235);
    sram_din = 8'h55;
    run_to(8);
    check_eq("vid_strobe", vid_strobe, 1);
    check_eq("vid_data", vid_data, 16'h55AA);
    next_cycle();
    check_eq("vid_strobe_one_cycle", vid_strobe, 0);
    run_to(15);
    check_eq("vid_we_n_never_low", we_low_cnt, 0);
    check_eq("vid_oe_low", sram_dout_oe, 0);

    // CPU read requested at slot 5
    run_to(5);
    clear_monitors();
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 21'h1C000;
    sram_din = 8'h3E;
    run_to(8);
    check_eq("rd_addr", sram_addr, 21'h1C000);
    check_eq("rd_we_n", sram_we_n, 1);
    run_to(11);
    check_eq("rd_ack_not_early", cpu_ack, 0);
    next_cycle();
    check_eq("rd_ack", cpu_ack, 1);
    check_eq("rd_rdata", cpu_rdata, 8'h3E);
    check_eq("rd_host_ack_quiet", host_ack, 0);
    cpu_req = 1'b0;
    sram_din = 8'h00;
    next_cycle();
    check_eq("rd_ack_one_cycle", cpu_ack, 0);
    check_eq("rd_rdata_held", cpu_rdata, 8'h3E);
    run_to(12);
    check_eq("rd_single_ack", cpu_ack_cnt, 1);
    check_eq("rd_no_write", we_low_cnt, 0);

    // Contention: CPU write in W2, host write in W3
    run_to(0);
    clear_monitors();
    cpu_req    = 1'b1;
    cpu_we     = 1'b1;
    cpu_addr   = 21'h00010;
    cpu_wdata  = 8'h11;
    host_req   = 1'b1;
    host_addr  = 21'h10000;
    host_wdata = 8'h22;
    run_to(8);
    check_eq("ct_cpu_addr", sram_addr, 21'h00010);
    check_eq("ct_p0_we_n", sram_we_n, 1);
    next_cycle();
    check_eq("ct_cpu_we_n_9", sram_we_n, 0);
    check_eq("ct_cpu_oe_9", sram_dout_oe, 1);
    check_eq("ct_cpu_dout", sram_dout, 8'h11);
    next_cycle();
    check_eq("ct_cpu_we_n_10", sram_we_n, 0);
    next_cycle();
    check_eq("ct_cpu_we_n_11", sram_we_n, 1);
    check_eq("ct_cpu_oe_hold_11", sram_dout_oe, 1);
    next_cycle();
    check_eq("ct_cpu_ack", cpu_ack, 1);
    check_eq("ct_host_ack_not_yet", host_ack, 0);
    check_eq("ct_host_addr", sram_addr, 21'h10000);
    check_eq("ct_oe_drop_p0", sram_dout_oe, 0);
    check_eq("ct_rdata_unchanged", cpu_rdata, 8'h3E);
    cpu_req = 1'b0;
    next_cycle();
    check_eq("ct_host_we_n_13", sram_we_n, 0);
    check_eq("ct_host_dout", sram_dout, 8'h22);
    next_cycle();
    check_eq("ct_host_we_n_14", sram_we_n, 0);
    next_cycle();
    check_eq("ct_host_we_n_15", sram_we_n, 1);
    next_cycle();
    check_eq("ct_host_ack", host_ack, 1);
    check_eq("ct_cpu_ack_quiet", cpu_ack, 0);
    check_eq("ct_vid_addr_next_frame", sram_addr, 21'h01234);
    host_req = 1'b0;
    run_to(15);
    check_eq("ct_cpu_ack_count", cpu_ack_cnt, 1);
    check_eq("ct_host_ack_count", host_ack_cnt, 1);
    check_eq("ct_we_low_cycles", we_low_cnt, 4);

    // resync at slot 9 aborts a CPU write, which then retries
    run_to(0);
    clear_monitors();
    cpu_req   = 1'b1;
    cpu_we    = 1'b1;
    cpu_addr  = 21'h00020;
    cpu_wdata = 8'h5A;
    run_to(9);
    check_eq("rs_we_n_before", sram_we_n, 0);
    resync = 1'b1;
    next_cycle();
    resync = 1'b0;
    check_eq("rs_we_n_released", sram_we_n, 1);
    check_eq("rs_oe_released", sram_dout_oe, 0);
    check_eq("rs_counter_zero_addr", sram_addr, 21'h01234);
    check_eq("rs_no_ack", cpu_ack, 0);
    run_to(9);
    check_eq("rs_retry_we_n", sram_we_n, 0);
    check_eq("rs_retry_dout", sram_dout, 8'h5A);
    run_to(12);
    check_eq("rs_retry_ack", cpu_ack, 1);
    cpu_req = 1'b0;
    next_cycle();
    check_eq("rs_ack_count", cpu_ack_cnt, 1);

    // rst asserted mid host write (host gets W2 as CPU is idle)
    run_to(0);
    host_req   = 1'b1;
    host_addr  = 21'h00300;
    host_wdata = 8'h77;
    run_to(8);
    check_eq("rst_host_addr_w2", sram_addr, 21'h00300);
    run_to(10);
    check_eq("rst_we_n_before", sram_we_n, 0);
    #2;
    rst = 1'b1;
    #1;
    check_eq("rst_async_we_n", sram_we_n, 1);
    check_eq("rst_async_oe", sram_dout_oe, 0);
    next_cycle();
    next_cycle();
    check_reset_values("rst_mid");
    rst = 1'b0;
    cnt_m = 0;
    clear_monitors();
    run_to(8);
    check_eq("rst_after_addr", sram_addr, 21'h00300);
    next_cycle();
    check_eq("rst_after_we_n", sram_we_n, 0);
    check_eq("rst_after_dout", sram_dout, 8'h77);
    run_to(12);
    check_eq("rst_after_host_ack", host_ack, 1);
    check_eq("rst_after_cpu_quiet", cpu_ack, 0);
    host_req = 1'b0;
    run_to(0);
    check_eq("rst_after_ack_count", host_ack_cnt, 1);

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
